// File: rtl/fft16_mag_serializer_if.sv
// fft16_mag_serializer_if: frame capture inputs and valid/ready beat outputs of the bin serializer
interface fft16_mag_serializer_if #(
    parameter int WORD_SIZE = 16,
    parameter int POINTS    = 16
);
    logic                          i_frame_done;
    logic [POINTS*WORD_SIZE-1:0]   i_re_bus;
    logic [POINTS*WORD_SIZE-1:0]   i_im_bus;
    logic                          i_ready;
    logic                          o_valid;
    logic [3:0]                    o_bin;
    logic [WORD_SIZE-1:0]          o_re;
    logic [WORD_SIZE-1:0]          o_im;
    logic [WORD_SIZE-1:0]          o_mag;
    logic                          o_last;
    logic                          o_busy;
    logic                          o_overrun;

    modport slave (
        input  i_frame_done, i_re_bus, i_im_bus, i_ready,
        output o_valid, o_bin, o_re, o_im, o_mag, o_last, o_busy, o_overrun
    );

    modport master (
        output i_frame_done, i_re_bus, i_im_bus, i_ready,
        input  o_valid, o_bin, o_re, o_im, o_mag, o_last, o_busy, o_overrun
    );
endinterface

// File: rtl/fft16_mag_serializer.sv
// fft16_mag_serializer: captures a 16-bin FFT frame and streams it bin by bin with an
// alpha-max-beta-min magnitude estimate over valid/ready.
module fft16_mag_serializer #(
    parameter int WORD_SIZE = 16,
    parameter int FRACTION  = 8,
    parameter int POINTS    = 16
) (
    input logic                   i_clk,
    input logic                   i_rst,
    fft16_mag_serializer_if.slave bus
);
    typedef enum logic {IDLE, STREAM} state_t;
    typedef logic [WORD_SIZE-1:0] word_t;

    if (FRACTION < 0 || FRACTION >= WORD_SIZE || POINTS != 16) begin : g_bad_params
        $error("fft16_mag_serializer: unsupported FRACTION/POINTS");
    end

    state_t             state_q;
    word_t [POINTS-1:0] re_sh_q, im_sh_q;
    logic [3:0]         bin_q, bin_d;
    word_t              re_q, im_q, mag_q;
    word_t              re_d, im_d, mag_d, a, b;
    logic               overrun_q;
    logic               hs, final_hs, accept;

    // A frame arriving with the last handshake is taken straight from the buses, so no bubble.
    always_comb begin
        hs       = state_q == STREAM && bus.i_ready;
        final_hs = hs && bin_q == 4'(POINTS - 1);
        accept   = bus.i_frame_done && (state_q == IDLE || final_hs);
        bin_d    = accept ? 4'd0 : bin_q + 4'd1;
        re_d     = accept ? bus.i_re_bus[WORD_SIZE-1:0] : re_sh_q[bin_d];
        im_d     = accept ? bus.i_im_bus[WORD_SIZE-1:0] : im_sh_q[bin_d];
        a        = re_d[WORD_SIZE-1] ? -re_d : re_d;
        b        = im_d[WORD_SIZE-1] ? -im_d : im_d;
        mag_d    = (a > b) ? a + (b >> 2) : b + (a >> 2);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            re_sh_q   <= '0;
            im_sh_q   <= '0;
            bin_q     <= '0;
            re_q      <= '0;
            im_q      <= '0;
            mag_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= bus.i_frame_done && state_q == STREAM && !final_hs;
            if (accept) begin
                re_sh_q <= bus.i_re_bus;
                im_sh_q <= bus.i_im_bus;
                state_q <= STREAM;
            end else if (final_hs) begin
                state_q <= IDLE;
            end
            if (accept || (hs && !final_hs)) begin
                bin_q <= bin_d;
                re_q  <= re_d;
                im_q  <= im_d;
                mag_q <= mag_d;
            end
        end
    end

    assign bus.o_valid   = state_q == STREAM;
    assign bus.o_busy    = state_q == STREAM;
    assign bus.o_bin     = bin_q;
    assign bus.o_re      = re_q;
    assign bus.o_im      = im_q;
    assign bus.o_mag     = mag_q;
    assign bus.o_last    = state_q == STREAM && bin_q == 4'(POINTS - 1);
    assign bus.o_overrun = overrun_q;
endmodule

// File: tb/tb_fft16_mag_serializer.sv
// tb_fft16_mag_serializer: directed checks of capture, streaming, backpressure, overrun,
// back-to-back frames and asynchronous reset.
module tb_fft16_mag_serializer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    logic [15:0] are[16], aim[16], amag[16];
    logic [15:0] bre[16], bim[16], bmag[16];

    fft16_mag_serializer_if bus_if ();

    fft16_mag_serializer dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_if.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic set_frame(input bit use_b);
        for (int k = 0; k < 16; k++) begin
            bus_if.i_re_bus[k*16 +: 16] = use_b ? bre[k] : are[k];
            bus_if.i_im_bus[k*16 +: 16] = use_b ? bim[k] : aim[k];
        end
    endtask

    task automatic pulse;
        bus_if.i_frame_done = 1'b1;
        tick();
        bus_if.i_frame_done = 1'b0;
    endtask

    task automatic check_beat(input string tag, input int k, input bit use_b);
        chk($sformatf("%s_valid%0d", tag, k), bus_if.o_valid, 1);
        chk($sformatf("%s_bin%0d", tag, k), bus_if.o_bin, k);
        chk($sformatf("%s_re%0d", tag, k), bus_if.o_re, use_b ? bre[k] : are[k]);
        chk($sformatf("%s_im%0d", tag, k), bus_if.o_im, use_b ? bim[k] : aim[k]);
        chk($sformatf("%s_mag%0d", tag, k), bus_if.o_mag, use_b ? bmag[k] : amag[k]);
        chk($sformatf("%s_last%0d", tag, k), bus_if.o_last, k == 15);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, bus_if.o_valid, 0);
        chk({tag, "_bin"}, bus_if.o_bin, 0);
        chk({tag, "_re"}, bus_if.o_re, 0);
        chk({tag, "_im"}, bus_if.o_im, 0);
        chk({tag, "_mag"}, bus_if.o_mag, 0);
        chk({tag, "_last"}, bus_if.o_last, 0);
        chk({tag, "_busy"}, bus_if.o_busy, 0);
        chk({tag, "_overrun"}, bus_if.o_overrun, 0);
    endtask

    task automatic run_to(input int n);
        int g = 0;
        while (!(bus_if.o_valid === 1'b1 && bus_if.o_bin == 4'(n)) && g < 40) begin
            tick();
            g++;
        end
        chk($sformatf("reach_bin%0d", n), bus_if.o_bin, n);
    endtask

    initial begin
        int  nb;
        int  cyc;
        bit  rdy;
        for (int k = 0; k < 16; k++) begin
            are[k] = '0; aim[k] = '0; amag[k] = '0;
            bre[k] = 16'(16'h0030 + 3 * k); bim[k] = '0; bmag[k] = bre[k];
        end
        are[0] = 16'h0100; aim[0] = 16'h00C9; amag[0] = 16'h0132;
        are[3] = 16'hFE00; aim[3] = 16'h0100; amag[3] = 16'h0240;
        bre[5] = 16'h8000; bim[5] = 16'h8000; bmag[5] = 16'hA000;
        bre[6] = 16'h7FFF; bim[6] = 16'h0000; bmag[6] = 16'h7FFF;
        bre[7] = 16'hFFFF; bim[7] = 16'hFFFF; bmag[7] = 16'h0001;
        bre[9] = 16'h0004; bim[9] = 16'hFFF0; bmag[9] = 16'h0011;
        bus_if.i_frame_done = 1'b0;
        bus_if.i_ready = 1'b0;
        set_frame(0);
        tick();
        check_zero("reset");
        rst = 1'b0;
        tick();
        chk("idle_valid", bus_if.o_valid, 0);
        // Single frame, consumer always ready
        bus_if.i_ready = 1'b1;
        pulse();
        for (int k = 0; k < 16; k++) begin
            check_beat("single", k, 0);
            tick();
        end
        chk("single_end_valid", bus_if.o_valid, 0);
        chk("single_end_busy", bus_if.o_busy, 0);
        chk("single_end_last", bus_if.o_last, 0);
        // Backpressure with ready pattern 1,0,0,1 over the extremes frame
        bus_if.i_ready = 1'b0;
        set_frame(1);
        pulse();
        nb = 0;
        cyc = 0;
        while (nb < 16 && cyc < 200) begin
            check_beat("bp", nb, 1);
            rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
            bus_if.i_ready = rdy;
            tick();
            if (rdy) nb++;
            cyc++;
        end
        chk("bp_beats", nb, 16);
        chk("bp_end_valid", bus_if.o_valid, 0);
        // Overrun: second frame while bin 4 is presented
        bus_if.i_ready = 1'b1;
        set_frame(0);
        pulse();
        run_to(4);
        set_frame(1);
        bus_if.i_frame_done = 1'b1;
        tick();
        bus_if.i_frame_done = 1'b0;
        chk("ovr_pulse", bus_if.o_overrun, 1);
        check_beat("ovr", 5, 0);
        tick();
        chk("ovr_clear", bus_if.o_overrun, 0);
        for (int k = 6; k < 16; k++) begin
            check_beat("ovr", k, 0);
            tick();
        end
        chk("ovr_end_valid", bus_if.o_valid, 0);
        // Back-to-back: new frame coincident with the bin-15 handshake
        set_frame(0);
        pulse();
        run_to(15);
        check_beat("b2b_pre", 15, 0);
        set_frame(1);
        bus_if.i_frame_done = 1'b1;
        tick();
        bus_if.i_frame_done = 1'b0;
        chk("b2b_overrun", bus_if.o_overrun, 0);
        check_beat("b2b", 0, 1);
        tick();
        check_beat("b2b", 1, 1);
        // Asynchronous reset between clock edges at bin 8
        run_to(8);
        check_beat("pre_rst", 8, 1);
        #2 rst = 1'b1;
        #1 check_zero("async_rst");
        #1 rst = 1'b0;
        tick();
        chk("post_rst_valid", bus_if.o_valid, 0);
        chk("post_rst_busy", bus_if.o_busy, 0);
        tick();
        chk("post_rst_valid2", bus_if.o_valid, 0);
        set_frame(0);
        pulse();
        check_beat("restart", 0, 0);
        tick();
        check_beat("restart", 1, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fft16_mag_serializer.md
Name: fft16_mag_serializer

Overview:
- Downstream stage of the 16-point FFT core.
- Captures the 16 parallel complex bins when the core signals frame completion.
- Streams the bins out one per handshake over a valid/ready interface, each with an approximate magnitude.
- Decouples the parallel FFT result from a narrow consumer (UART packer, peak detector, display).

Parameters:
WORD_SIZE  16  width of each signed two's-complement real/imag sample
FRACTION   8   fractional bits of samples; pass-through only, magnitude keeps the same scaling
POINTS     16  number of bins per frame; fixed at 16, index width 4

Ports:
i_clk         input   1                  rising-edge clock
i_rst         input   1                  asynchronous, active-high reset
i_frame_done  input   1                  one-cycle pulse from FFT core o_FFT_cycle_done; buses valid in that cycle
i_re_bus      input   POINTS*WORD_SIZE   real parts; bin k at [k*WORD_SIZE +: WORD_SIZE]
i_im_bus      input   POINTS*WORD_SIZE   imag parts, same packing
i_ready       input   1                  consumer accepts current beat
o_valid       output  1                  beat valid
o_bin         output  4                  bin index of current beat
o_re          output  WORD_SIZE          bin real part (signed)
o_im          output  WORD_SIZE          bin imag part (signed)
o_mag         output  WORD_SIZE          unsigned magnitude estimate
o_last        output  1                  high with bin 15 beat
o_busy        output  1                  frame being streamed (state STREAM)
o_overrun     output  1                  one-cycle pulse: frame dropped because stream still in progress

Behaviour:
- Reset (async, any time including mid-stream): state IDLE; all outputs 0; stored frame discarded; index 0.
- States:
  - IDLE: o_valid=0.
  - STREAM: o_valid=1.
- IDLE + i_frame_done: on that edge, store all 16 bins in shadow registers, load output registers with bin 0, index=0, go STREAM. o_valid high the next cycle (1-cycle latency).
- Handshake = o_valid & i_ready at a rising edge.
  - Handshake with index<15: outputs load bin index+1 from shadow.
  - Handshake with index=15: return to IDLE, o_valid=0.
- o_valid & !i_ready: o_bin/o_re/o_im/o_mag/o_last held stable; no beat skipped or repeated.
- i_frame_done in STREAM, without a final handshake in the same cycle: new frame ignored, shadow unchanged, o_overrun=1 for one cycle.
- i_frame_done in the same cycle as the index-15 handshake: new frame accepted, no overrun. Next cycle presents new bin 0 with o_valid continuously high (no bubble).
- o_last = (o_bin==15) & o_valid. o_busy = (state==STREAM).
- Magnitude, alpha-max-beta-min (alpha=1, beta=1/4):
  - a = |re|, b = |im|, each unsigned WORD_SIZE bits; |-2^(WORD_SIZE-1)| = 2^(WORD_SIZE-1), no saturation.
  - mag = max(a,b) + (min(a,b) >> 2), truncated shift.
  - Maximum value 2^(WS-1) + 2^(WS-3) fits in WORD_SIZE unsigned, so no overflow handling.
  - Computed combinationally from the selected bin and registered with o_re/o_im, so magnitude is aligned with its bin.
- Bins are emitted in natural order 0..15 exactly as presented on the buses; no reordering.

Test Plan:
- Reset then single frame: bin0 re=0x0100 im=0x00C9, bin3 re=0xFE00 im=0x0100, others 0; i_ready=1.
  - o_valid rises 1 cycle after the pulse; 16 consecutive beats.
  - bin0 o_mag=0x0132; bin3 o_mag=0x0240; others 0.
  - o_last only on bin 15; o_valid falls next cycle.
- Backpressure: i_ready toggled 1,0,0,1 repeatedly.
  - Outputs held during low cycles; all 16 bins delivered once, in order, with no duplicates.
- Extremes: bin5 re=0x8000 im=0x8000 -> o_mag=0xA000. bin6 re=0x7FFF im=0x0000 -> o_mag=0x7FFF. bin7 re=0xFFFF im=0xFFFF -> o_mag=0x0001.
- Overrun: second i_frame_done while streaming bin 4 with i_ready=1.
  - o_overrun pulses 1 cycle; bins 5..15 still come from frame 1; frame 2 data never appears.
- Back-to-back: i_frame_done coincident with the bin-15 handshake.
  - No o_overrun; next cycle o_valid=1, o_bin=0 carrying frame 2 data.
- Async reset asserted mid-stream at bin 8, without a clock edge.
  - All outputs 0 immediately; after release, idle until the next i_frame_done, then restart at bin 0.
